decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// ============================================================================
//  Module      : decode_stage
//  Description : Single-entry pipelined instruction decode stage. Splits the
//                16-bit instruction into register-file read addresses, latches
//                operands / immediate / destination into a valid-ready output
//                bundle, and inserts one bubble for a load-use dependency on
//                the most recently issued LW.
//  Options     : DECODE_WB_BYPASS_EN - forward writeback data into the
//                operand capture when the writeback targets rs / rt.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    output logic [2:0]  rf_read_reg1,
    output logic [2:0]  rf_read_reg2,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2,
    input  logic        wb_reg_write,
    input  logic [2:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [2:0]  out_dest,
    output logic        out_reg_write,
    output logic [31:0] out_op_a,
    output logic [31:0] out_op_b,
    output logic [31:0] out_imm
);

    // Opcode encodings
    localparam logic [3:0] c_OP_RTYPE = 4'b0000;
    localparam logic [3:0] c_OP_ADDI  = 4'b0010;
    localparam logic [3:0] c_OP_LW    = 4'b0100;
    localparam logic [3:0] c_OP_SW    = 4'b0101;
    localparam logic [3:0] c_OP_BEQ   = 4'b0110;

    // Hazard-control states
    localparam logic [0:0] c_ST_RUN    = 1'b0;
    localparam logic [0:0] c_ST_HAZARD = 1'b1;

    // Instruction fields
    logic [3:0]  w_opcode;
    logic [2:0]  w_rs;
    logic [2:0]  w_rt;
    logic [2:0]  w_rd;

    // Decoded fields of the offered instruction
    logic [2:0]  w_dest;
    logic        w_reg_write;
    logic        w_uses_rt;
    logic [31:0] w_imm;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;

    // Handshake / hazard control
    logic        w_stall;
    logic        w_accept;
    logic        w_drain;
    logic        w_lw_xfer;
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [2:0]  r_load_dest;

    // Output bundle registers
    logic        r_out_valid;
    logic [3:0]  r_out_opcode;
    logic [2:0]  r_out_dest;
    logic        r_out_reg_write;
    logic [31:0] r_out_op_a;
    logic [31:0] r_out_op_b;
    logic [31:0] r_out_imm;

    assign w_opcode = instr[15:12];
    assign w_rs     = instr[11:9];
    assign w_rt     = instr[8:6];
    assign w_rd     = instr[5:3];

    // Register-file addresses come straight from the instruction so the
    // read data is available in the same cycle the instruction is offered.
    assign rf_read_reg1 = w_rs;
    assign rf_read_reg2 = w_rt;

    assign w_imm = {{26{instr[5]}}, instr[5:0]};

    // Opcode decode: destination, write enable and whether rt is a source
    always_comb begin
        w_dest      = 3'd0;
        w_reg_write = 1'b0;
        w_uses_rt   = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_dest      = w_rd;
                w_reg_write = 1'b1;
                w_uses_rt   = 1'b1;
            end
            c_OP_ADDI,
            c_OP_LW: begin
                w_dest      = w_rt;
                w_reg_write = 1'b1;
            end
            c_OP_SW,
            c_OP_BEQ: begin
                w_uses_rt   = 1'b1;
            end
            default: begin
                w_dest      = 3'd0;
                w_reg_write = 1'b0;
            end
        endcase
        // r0 is hard-wired, so a write to it is never requested.
        if (w_dest == 3'd0) begin
            w_reg_write = 1'b0;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    // Forward the writeback value when it targets a source register that the
    // register file has not yet been updated with this cycle.
    always_comb begin
        w_op_a = rf_read_data1;
        w_op_b = rf_read_data2;
        if (wb_reg_write && (wb_write_reg == w_rs) && (w_rs != 3'd0)) begin
            w_op_a = wb_write_data;
        end
        if (wb_reg_write && (wb_write_reg == w_rt) && (w_rt != 3'd0)) begin
            w_op_b = wb_write_data;
        end
    end
`else
    assign w_op_a = rf_read_data1;
    assign w_op_b = rf_read_data2;

    // Writeback port is not consumed without forwarding.
    logic w_unused_wb;
    assign w_unused_wb = &{1'b0, wb_reg_write, wb_write_reg, wb_write_data};
`endif

    // A load whose destination is live leaves the output register this cycle.
    assign w_lw_xfer = r_out_valid && out_ready &&
                       (r_out_opcode == c_OP_LW) && (r_out_dest != 3'd0);

    assign w_drain   = r_out_valid && out_ready;
    assign in_ready  = (!r_out_valid || out_ready) && !w_stall;
    assign w_accept  = in_valid && in_ready;

    // Hazard FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Hazard FSM next state: HAZARD always lasts exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (w_lw_xfer) begin
                    w_state_nxt = c_ST_HAZARD;
                end
            end
            c_ST_HAZARD: begin
                w_state_nxt = c_ST_RUN;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    // Hazard FSM output: stall an offered instruction that sources the load
    always_comb begin
        w_stall = 1'b0;
        if ((r_state == c_ST_HAZARD) && in_valid) begin
            if (w_rs == r_load_dest) begin
                w_stall = 1'b1;
            end
            if (w_uses_rt && (w_rt == r_load_dest)) begin
                w_stall = 1'b1;
            end
        end
    end

    // Remember which register the transferring load will write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_dest <= 3'd0;
        end else if ((r_state == c_ST_RUN) && w_lw_xfer) begin
            r_load_dest <= r_out_dest;
        end
    end

    // Output bundle: load on accept, invalidate on drain, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_out_opcode    <= 4'd0;
            r_out_dest      <= 3'd0;
            r_out_reg_write <= 1'b0;
            r_out_op_a      <= 32'd0;
            r_out_op_b      <= 32'd0;
            r_out_imm       <= 32'd0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_out_opcode    <= w_opcode;
            r_out_dest      <= w_dest;
            r_out_reg_write <= w_reg_write;
            r_out_op_a      <= w_op_a;
            r_out_op_b      <= w_op_b;
            r_out_imm       <= w_imm;
        end else if (w_drain) begin
            r_out_valid     <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_opcode    = r_out_opcode;
    assign out_dest      = r_out_dest;
    assign out_reg_write = r_out_reg_write;
    assign out_op_a      = r_out_op_a;
    assign out_op_b      = r_out_op_b;
    assign out_imm       = r_out_imm;

endmodule

`default_nettype wire
